// File: rtl/vga_timing_pkg.sv
// Shared constants, sizing helpers and the sync-triple type for the VGA timing generator.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int SYNC_W = 3;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
  } sync_t;

  function automatic int h_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

  // Never returns less than 1 so a single-state counter still has a legal width.
  function automatic int clog2(input int val);
    int r;
    r = 1;
    while ((1 << r) < val) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-enabled, resettable shift register delaying the {hsync, vsync, video} triple by DEPTH pixels.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic [SYNC_W-1:0] d_i,
  output logic [SYNC_W-1:0] q_o
);

  logic [SYNC_W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (tick_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock enable and delayed sync/video outputs.
// Optional field-blink output enabled by defining VGA_TIMING_BLINK_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV      = 4,
  parameter int   H_ACTIVE     = H_ACTIVE_DEF,
  parameter int   H_FP         = H_FP_DEF,
  parameter int   H_SYNC       = H_SYNC_DEF,
  parameter int   H_BP         = H_BP_DEF,
  parameter int   V_ACTIVE     = V_ACTIVE_DEF,
  parameter int   V_FP         = V_FP_DEF,
  parameter int   V_SYNC       = V_SYNC_DEF,
  parameter int   V_BP         = V_BP_DEF,
  parameter logic HS_POL       = 1'b0,
  parameter logic VS_POL       = 1'b0,
  parameter int   PIPE_DEPTH   = 2,
  parameter int   COORD_W      = 10,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic               reloj_nexys,
  input  logic               reset_total,
  output logic               pix_tick,
  output logic [COORD_W-1:0] x_p,
  output logic [COORD_W-1:0] y_p,
  output logic               hsync,
  output logic               vsync,
  output logic               ON_VID,
  output logic               line_start,
`ifdef VGA_TIMING_BLINK_EN
  output logic               frame_start,
  output logic               blink
`else
  output logic               frame_start
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16 || PIPE_DEPTH < 0 || PIPE_DEPTH > 7 || BLINK_FRAMES < 1 ||
      H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_cfg
    $error("vga_timing_gen: parameter out of range");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_q, tick_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               ls_q, ls_d, fs_q, fs_d;
  sync_t              raw_q, raw_d;
  sync_t              dly_s;

  // The raw triple is derived from the next coordinates so it is registered alongside them.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    tick_d = 1'b0;
    x_d    = x_q;
    y_d    = y_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    raw_d  = raw_q;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
    if (tick_q) begin
      if (x_q == H_LAST) begin
        x_d  = '0;
        ls_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d  = y_q + COORD_W'(1);
        end
      end else begin
        x_d = x_q + COORD_W'(1);
      end
      raw_d.hs  = (x_d >= HS_FIRST) && (x_d <= HS_LAST);
      raw_d.vs  = (y_d >= VS_FIRST) && (y_d <= VS_LAST);
      raw_d.vid = (x_d < H_VIS) && (y_d < V_VIS);
    end else begin
      raw_d = raw_q;
    end
  end

  always_ff @(posedge reloj_nexys) begin
    if (reset_total) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      raw_q  <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      raw_q  <= raw_d;
    end
  end

  if (PIPE_DEPTH == 0) begin : g_no_dly
    assign dly_s = raw_q;
  end else begin : g_dly
    vga_sync_delay #(.DEPTH(PIPE_DEPTH)) u_dly (
      .clk_i  (reloj_nexys),
      .rst_i  (reset_total),
      .tick_i (tick_q),
      .d_i    (raw_q),
      .q_o    (dly_s)
    );
  end

`ifdef VGA_TIMING_BLINK_EN
  localparam int             BLK_W    = clog2(BLINK_FRAMES);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_q, blink_d;

  // Frame counter advancing on each frame strobe; blink flips on its wrap.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    blink_d   = blink_q;
    if (fs_q) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end else begin
      blk_cnt_d = blk_cnt_q;
    end
  end

  always_ff @(posedge reloj_nexys) begin
    if (reset_total) begin
      blk_cnt_q <= '0;
      blink_q   <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
    end
  end

  assign blink = blink_q;
`endif

  assign pix_tick    = tick_q;
  assign x_p         = x_q;
  assign y_p         = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign hsync       = dly_s.hs ^ ~HS_POL;
  assign vsync       = dly_s.vs ^ ~VS_POL;
  assign ON_VID      = dly_s.vid;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 generator and a tiny fast-wrapping one run side by side.
module tb_vga_timing_gen;

  typedef struct packed {
    int clk_div; int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp; int depth; int blink_frames;
    bit hpol; bit vpol;
  } cfg_t;

  typedef struct packed {
    int div; bit tick; int x; int y; bit ls; bit fs;
    logic [7:0][2:0] hist; int bcnt; bit blink;
  } st_t;

  typedef struct packed {
    bit tick; int x; int y; bit hs; bit vs; bit on; bit ls; bit fs; bit blink;
  } exp_t;

  localparam cfg_t DCFG = '{clk_div:4, ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2,
                            vbp:33, depth:2, blink_frames:30, hpol:1'b0, vpol:1'b0};
  localparam cfg_t SCFG = '{clk_div:1, ha:8, hfp:2, hsw:2, hbp:2, va:4, vfp:1, vsw:1,
                            vbp:1, depth:0, blink_frames:2, hpol:1'b1, vpol:1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       d_tick, d_hs, d_vs, d_on, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_tick, s_hs, s_vs, s_on, s_ls, s_fs;
  logic [3:0] s_x, s_y;
`ifdef VGA_TIMING_BLINK_EN
  logic       d_blink, s_blink;
`endif

  vga_timing_gen u_def (
    .reloj_nexys (clk), .reset_total (rst), .pix_tick (d_tick), .x_p (d_x), .y_p (d_y),
    .hsync (d_hs), .vsync (d_vs), .ON_VID (d_on), .line_start (d_ls),
`ifdef VGA_TIMING_BLINK_EN
    .frame_start (d_fs), .blink (d_blink)
`else
    .frame_start (d_fs)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .HS_POL (1'b1), .VS_POL (1'b0),
    .PIPE_DEPTH (0), .COORD_W (4), .BLINK_FRAMES (2)
  ) u_sml (
    .reloj_nexys (clk), .reset_total (rst), .pix_tick (s_tick), .x_p (s_x), .y_p (s_y),
    .hsync (s_hs), .vsync (s_vs), .ON_VID (s_on), .line_start (s_ls),
`ifdef VGA_TIMING_BLINK_EN
    .frame_start (s_fs), .blink (s_blink)
`else
    .frame_start (s_fs)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_dtick = -1, last_dls = -1, last_sls = -1, last_sfs = -1;
  st_t  ds = '0, ss = '0;
  exp_t q_def[$], q_sml[$];
  bit   found;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic st_t model_step(input cfg_t c, input st_t s, input bit r);
    st_t n;
    int  ht, vt, hs0, vs0;
    n   = s;
    ht  = c.ha + c.hfp + c.hsw + c.hbp;
    vt  = c.va + c.vfp + c.vsw + c.vbp;
    hs0 = c.ha + c.hfp;
    vs0 = c.va + c.vfp;
    if (r) return '0;
    n.tick = (s.div == c.clk_div - 1);
    n.div  = n.tick ? 0 : s.div + 1;
    n.ls   = 1'b0;
    n.fs   = 1'b0;
    if (s.fs) begin
      if (s.bcnt == c.blink_frames - 1) begin
        n.bcnt  = 0;
        n.blink = ~s.blink;
      end else n.bcnt = s.bcnt + 1;
    end
    if (s.tick) begin
      n.ls = (s.x == ht - 1);
      n.fs = n.ls && (s.y == vt - 1);
      n.x  = n.ls ? 0 : s.x + 1;
      n.y  = n.ls ? ((s.y == vt - 1) ? 0 : s.y + 1) : s.y;
      for (int i = 7; i > 0; i--) n.hist[i] = s.hist[i-1];
      n.hist[0] = {(n.x >= hs0 && n.x < hs0 + c.hsw), (n.y >= vs0 && n.y < vs0 + c.vsw),
                   (n.x < c.ha && n.y < c.va)};
    end
    return n;
  endfunction

  function automatic exp_t model_out(input cfg_t c, input st_t s);
    exp_t e;
    logic [2:0] t;
    t       = s.hist[c.depth];
    e.tick  = s.tick;
    e.x     = s.x;
    e.y     = s.y;
    e.hs    = t[2] ? c.hpol : ~c.hpol;
    e.vs    = t[1] ? c.vpol : ~c.vpol;
    e.on    = t[0];
    e.ls    = s.ls;
    e.fs    = s.fs;
    e.blink = s.blink;
    return e;
  endfunction

  task automatic cmp(input string p, input exp_t e, input logic t, input logic [9:0] x,
                     input logic [9:0] y, input logic hs, input logic vs, input logic on,
                     input logic ls, input logic fs);
    check_eq({p, "_pix_tick"}, 32'(t), 32'(e.tick));
    check_eq({p, "_x_p"}, 32'(x), e.x);
    check_eq({p, "_y_p"}, 32'(y), e.y);
    check_eq({p, "_hsync"}, 32'(hs), 32'(e.hs));
    check_eq({p, "_vsync"}, 32'(vs), 32'(e.vs));
    check_eq({p, "_on_vid"}, 32'(on), 32'(e.on));
    check_eq({p, "_line_start"}, 32'(ls), 32'(e.ls));
    check_eq({p, "_frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  task automatic run_cycle();
    exp_t ed, es;
    @(posedge clk);
    if (rst) begin
      last_dtick = -1; last_dls = -1; last_sls = -1; last_sfs = -1;
    end
    ds = model_step(DCFG, ds, rst);
    ss = model_step(SCFG, ss, rst);
    q_def.push_back(model_out(DCFG, ds));
    q_sml.push_back(model_out(SCFG, ss));
    cyc++;
    @(negedge clk);
    ed = q_def.pop_front();
    es = q_sml.pop_front();
    cmp("def", ed, d_tick, d_x, d_y, d_hs, d_vs, d_on, d_ls, d_fs);
    cmp("sml", es, s_tick, {6'd0, s_x}, {6'd0, s_y}, s_hs, s_vs, s_on, s_ls, s_fs);
`ifdef VGA_TIMING_BLINK_EN
    check_eq("def_blink", 32'(d_blink), 32'(ed.blink));
    check_eq("sml_blink", 32'(s_blink), 32'(es.blink));
`endif
    if (d_tick === 1'b1) begin
      if (last_dtick >= 0) check_eq("def_tick_period", cyc - last_dtick, 4);
      last_dtick = cyc;
    end
    if (d_ls === 1'b1) begin
      if (last_dls >= 0) check_eq("def_line_period", cyc - last_dls, 3200);
      last_dls = cyc;
    end
    if (s_ls === 1'b1) begin
      if (last_sls >= 0) check_eq("sml_line_period", cyc - last_sls, 14);
      last_sls = cyc;
    end
    if (s_fs === 1'b1) begin
      if (last_sfs >= 0) check_eq("sml_frame_period", cyc - last_sfs, 98);
      last_sfs = cyc;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (4) run_cycle();
    rst = 1'b0;
    repeat (12000) run_cycle();
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (ds.x == 300) found = 1'b1;
      else run_cycle();
    end
    check_eq("wait_x300", 32'(found), 32'd1);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    repeat (6000) run_cycle();
    rst = 1'b1;
    repeat (3) run_cycle();
    rst = 1'b0;
    repeat (300) run_cycle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
